mdu_requester: RTL
==================

# mdu_requester

Execute-stage initiator for the M-extension multiply/divide unit. It detects an MDU instruction in execute, registers its operands, drives the MDU `req_valid`/`res_valid`/`res_ack` handshake, and stalls the pipeline until the result is captured. It also drains operations killed by a flush, and can optionally reuse the last result for identical back-to-back operations.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ex_valid` in 1: the execute-stage instruction is an MDU op. Held stable while `stall_req`=1.
- `ex_src1`, `ex_src2` in 32: operands.
- `ex_control` in `alu_control_t`: one of MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- `flush` in 1: kills the execute-stage instruction this cycle.
- `stall_req` out 1: freezes the pipeline front-end.
- `result` out 32: captured MDU result.
- `result_valid` out 1: `result` is valid this cycle. One-cycle pulse.
- `mdu_src1`, `mdu_src2` out 32: operands to the MDU.
- `mdu_control` out `alu_control_t`: op to the MDU.
- `req_valid` out 1: request to the MDU.
- `res_ack` out 1: acknowledge to the MDU.
- `res_valid` in 1: MDU result ready.
- `mdu_result` in 32: MDU result, meaningful only while `res_valid`=1.

## Operation
- FSM states: `REQ_IDLE`, `REQ_ISSUE`, `REQ_WAIT`, `REQ_DONE`, `REQ_DRAIN`.
- **IDLE**
  - If `ex_valid && !flush`: latch `ex_src1`/`ex_src2`/`ex_control` into operand registers, then go to ISSUE.
  - `stall_req = ex_valid && !flush`.
- **ISSUE**
  - `req_valid`=1 for exactly this one cycle, then go to WAIT. `req_valid` must never be high in any other state; the MDU restarts if it sees `req_valid` while idle.
  - `stall_req`=1.
- **WAIT**
  - When `res_valid`=1: `res_ack`=1 in the same cycle, register `mdu_result` into `result`, go to DONE.
  - `stall_req`=1.
- **DONE**
  - `result_valid`=1 and `stall_req`=0; the pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally.
  - `flush` in DONE suppresses `result_valid`.
- **Flush in ISSUE or WAIT**
  - Go to DRAIN. ISSUE still asserts `req_valid` that cycle, because the request is already committed.
  - If `res_valid` arrives in the same cycle as the flush, ack it and go straight to IDLE with no `result_valid`.
- **DRAIN**
  - On `res_valid`: `res_ack`=1, discard the result, go to IDLE.
  - `stall_req = ex_valid`, so a younger MDU op waits until the drain completes.
- **Operand hold**
  - `mdu_src1`/`mdu_src2`/`mdu_control` are driven from the operand registers at all times.
  - They stay stable from ISSUE through the ack cycle, because the MDU computes products combinationally from live inputs.
- **Reset values:** state IDLE, operand registers 0, `result` 0, `req_valid`/`res_ack`/`result_valid` 0. `stall_req` is 0 unless `ex_valid`.
- **Reset mid-operation:** returns to IDLE immediately. The MDU shares `rst_n`, so no drain is needed.

## Timing
- Cycle 0 is the first IDLE cycle with `ex_valid`.
- **MUL*:** ISSUE at c1, MDU DONE and ack at c2, `result_valid` at c3. Stall covers c0–c2.
- **DIV/REM (normal):** ISSUE c1, MDU BUSY c2–c33, ack c34, `result_valid` c35.
- **DIV/REM, divide-by-zero or signed overflow:** ack c3, `result_valid` c4.
- **Back-to-back MDU ops:** the second op's IDLE cycle is the cycle after DONE, giving a 1-cycle minimum issue gap.

## Configuration
- `MDU_REUSE_EN`
  - **Defined:** holds the last completed, non-drained `{control, src1, src2, result}` plus a valid bit. The valid bit clears on reset.
  - A hit in IDLE (`ex_valid`, exact match on all three keys) skips ISSUE/WAIT: load the cached result and go to DONE. `result_valid` at c1, no MDU request.
  - The cache is updated on every WAIT-to-DONE transition, including flushed-in-DONE ops.
  - **Undefined:** every op issues to the MDU; no cache storage.

## Structure
- **`holy_core_pkg`:** add the `mdu_req_state_t` enum holding the five states above. `alu_control_t` is reused unchanged.
- **Sub-module `mdu_reuse_cache`:** key compare, storage and hit output. Instantiated only under `MDU_REUSE_EN`.

## Test plan
- MUL `7 × 6`, `ex_valid` at c0 → one `req_valid` pulse at c1, `res_ack` at c2, `result`=42 and `result_valid` at c3; `stall_req` high c0–c2.
- DIV `-20 / 3` → `result`=`0xFFFFFFFA` at c35; REM with the same operands → `0xFFFFFFFE`.
- DIVU `x / 0` → `0xFFFFFFFF` at c4; REM `0x80000000 / -1` → 0 at c4.
- Flush at c5 of a DIVU → DRAIN, one `res_ack` at c34, no `result_valid`.
  - A following MUL presented at c6 is stalled until c34 and issues at c35+1.
- `MDU_REUSE_EN`: MULHU `0xFFFFFFFF × 2` twice back-to-back → first result `1` via the MDU, second result `1` one cycle after its IDLE with no `req_valid`.
  - Change `src2` → the op reissues to the MDU.
- Assert `rst_n` low during WAIT of a DIV → next cycle IDLE with all outputs 0. A new MUL then completes with normal 3-cycle latency.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared core types: ALU/MDU operation encoding and the MDU requester state set.
package holy_core_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_control_t;

    typedef enum logic [2:0] {
        REQ_IDLE  = 3'd0,
        REQ_ISSUE = 3'd1,
        REQ_WAIT  = 3'd2,
        REQ_DONE  = 3'd3,
        REQ_DRAIN = 3'd4
    } mdu_req_state_t;

endpackage

// File: rtl/mdu_reuse_cache.sv
// Single-entry result cache: remembers the last completed MDU op and flags an
// exact {control, src1, src2} match against the execute-stage operands.
module mdu_reuse_cache
    import holy_core_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  alu_control_t i_lookup_control,
    input  logic [31:0]  i_lookup_src1,
    input  logic [31:0]  i_lookup_src2,
    output logic         o_hit,
    output logic [31:0]  o_result,
    input  logic         i_update,
    input  alu_control_t i_update_control,
    input  logic [31:0]  i_update_src1,
    input  logic [31:0]  i_update_src2,
    input  logic [31:0]  i_update_result
);

    logic         r_valid;
    alu_control_t r_control;
    logic [31:0]  r_src1;
    logic [31:0]  r_src2;
    logic [31:0]  r_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_control <= ALU_ADD;
            r_src1    <= '0;
            r_src2    <= '0;
            r_result  <= '0;
        end else if (i_update) begin
            r_valid   <= 1'b1;
            r_control <= i_update_control;
            r_src1    <= i_update_src1;
            r_src2    <= i_update_src2;
            r_result  <= i_update_result;
        end
    end

    assign o_hit = r_valid
                && (r_control == i_lookup_control)
                && (r_src1 == i_lookup_src1)
                && (r_src2 == i_lookup_src2);
    assign o_result = r_result;

endmodule

// File: rtl/mdu_requester.sv
// Execute-stage MDU initiator: latches operands, runs the req/res/ack handshake,
// stalls until the result lands and drains flushed ops. MDU_REUSE_EN adds result reuse.
module mdu_requester
    import holy_core_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ex_valid,
    input  logic [31:0]  ex_src1,
    input  logic [31:0]  ex_src2,
    input  alu_control_t ex_control,
    input  logic         flush,
    output logic         stall_req,
    output logic [31:0]  result,
    output logic         result_valid,
    output logic [31:0]  mdu_src1,
    output logic [31:0]  mdu_src2,
    output alu_control_t mdu_control,
    output logic         req_valid,
    output logic         res_ack,
    input  logic         res_valid,
    input  logic [31:0]  mdu_result
);

    mdu_req_state_t r_state;
    logic [31:0]    r_src1;
    logic [31:0]    r_src2;
    alu_control_t   r_control;
    logic [31:0]    r_result;
    logic           r_req_valid;

    logic           w_start;
    logic           w_cache_hit;
    logic [31:0]    w_cache_result;

    assign w_start = (r_state == REQ_IDLE) && ex_valid && !flush;

`ifdef MDU_REUSE_EN
    logic w_cache_update;

    // Flushed-in-DONE ops still refresh the cache; only drained results are dropped.
    assign w_cache_update = (r_state == REQ_WAIT) && res_valid && !flush;

    mdu_reuse_cache u_reuse_cache (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_lookup_control (ex_control),
        .i_lookup_src1    (ex_src1),
        .i_lookup_src2    (ex_src2),
        .o_hit            (w_cache_hit),
        .o_result         (w_cache_result),
        .i_update         (w_cache_update),
        .i_update_control (r_control),
        .i_update_src1    (r_src1),
        .i_update_src2    (r_src2),
        .i_update_result  (mdu_result)
    );
`else
    assign w_cache_hit    = 1'b0;
    assign w_cache_result = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= REQ_IDLE;
            r_src1      <= '0;
            r_src2      <= '0;
            r_control   <= ALU_ADD;
            r_result    <= '0;
            r_req_valid <= 1'b0;
        end else begin
            r_req_valid <= 1'b0;
            case (r_state)
                REQ_IDLE: begin
                    if (w_start) begin
                        r_src1    <= ex_src1;
                        r_src2    <= ex_src2;
                        r_control <= ex_control;
                        if (w_cache_hit) begin
                            r_result <= w_cache_result;
                            r_state  <= REQ_DONE;
                        end else begin
                            r_req_valid <= 1'b1;
                            r_state     <= REQ_ISSUE;
                        end
                    end
                end
                // The request is already on the wire, so a flush here must drain.
                REQ_ISSUE: r_state <= flush ? REQ_DRAIN : REQ_WAIT;
                REQ_WAIT: begin
                    if (res_valid) begin
                        if (flush) begin
                            r_state <= REQ_IDLE;
                        end else begin
                            r_result <= mdu_result;
                            r_state  <= REQ_DONE;
                        end
                    end else if (flush) begin
                        r_state <= REQ_DRAIN;
                    end
                end
                REQ_DONE:  r_state <= REQ_IDLE;
                REQ_DRAIN: if (res_valid) r_state <= REQ_IDLE;
                default:   r_state <= REQ_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req = 1'b0;
        case (r_state)
            REQ_IDLE:  stall_req = ex_valid && !flush;
            REQ_ISSUE: stall_req = 1'b1;
            REQ_WAIT:  stall_req = 1'b1;
            REQ_DONE:  stall_req = 1'b0;
            REQ_DRAIN: stall_req = ex_valid;
            default:   stall_req = 1'b0;
        endcase
    end

    // Operands stay on the MDU inputs through the ack, since products are computed live.
    assign mdu_src1     = r_src1;
    assign mdu_src2     = r_src2;
    assign mdu_control  = r_control;
    assign req_valid    = r_req_valid;
    assign res_ack      = res_valid && ((r_state == REQ_WAIT) || (r_state == REQ_DRAIN));
    assign result       = r_result;
    assign result_valid = (r_state == REQ_DONE) && !flush;

endmodule
